// File: rtl/hash_digest_drain_pkg.sv
// Shared constants and types for the hash digest drain: FSM encoding and digest geometry.
package hash_digest_drain_pkg;

  localparam int LANES_DEF     = 4;
  localparam int N_DIGESTS_DEF = 3;
  localparam int LANE_W        = 64;
  localparam int WORD_W        = 32;
  localparam int DIGEST_W      = 256;
  localparam int WORD_IDX_W    = $clog2(DIGEST_W / WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hash_digest_drain_word_mux.sv
// Selects one 32-bit word of the captured digest; word 0 is the low half of lane 0.
module digest_word_mux
  import hash_digest_drain_pkg::*;
(
  input  logic [DIGEST_W-1:0]   buffer,
  input  logic [WORD_IDX_W-1:0] word_idx,
  output logic [WORD_W-1:0]     word
);

  always_comb begin
    word = buffer[WORD_W*word_idx +: WORD_W];
  end

endmodule

// File: rtl/hash_digest_drain.sv
// Copies each finished sponge digest lane by lane into a local buffer, then streams it out
// as 32-bit words over a valid/ready port until N_DIGESTS digests have been drained.
module hash_digest_drain
  import hash_digest_drain_pkg::*;
#(
  parameter int N_DIGESTS = N_DIGESTS_DEF,
  parameter int LANES     = LANES_DEF
) (
  input  logic              clk,
  input  logic              ovr_rst1,
  input  logic              hash_ans,
  input  logic              hash_fin,
  input  logic [LANE_W-1:0] lane_in,
  output logic [1:0]        lane_sel,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        digest_cnt,
  output logic              all_done,
  output logic              overrun,
  output state_t            state_dbg
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data and out_valid do not change.

  localparam logic [1:0]            LAST_LANE = 2'(LANES - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(2 * LANES - 1);
  localparam logic [1:0]            N_CNT     = 2'(N_DIGESTS);

  state_t                state_q, state_d;
  logic [1:0]            lane_cnt;
  logic [WORD_IDX_W-1:0] word_cnt;
  logic [DIGEST_W-1:0]   buffer;
  logic [WORD_W-1:0]     mux_word;
  logic                  handshake;
  logic                  last_hs;
  logic                  overrun_set;

  assign handshake = (state_q == ST_SEND) && out_ready;
  assign last_hs   = handshake && (word_cnt == LAST_WORD);

  // Strobes while draining are dropped; an early finish in IDLE is flagged the same way.
  assign overrun_set = (hash_ans && ((state_q == ST_FETCH) || (state_q == ST_SEND))) ||
                       (hash_fin && (state_q == ST_IDLE) && (digest_cnt < N_CNT));

  always_ff @(posedge clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hash_ans) state_d = ST_FETCH;
      ST_FETCH: if (lane_cnt == LAST_LANE) state_d = ST_SEND;
      ST_SEND: begin
        if (last_hs) begin
          state_d = (digest_cnt + 2'd1 == N_CNT) ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_SEND);
    busy      = (state_q == ST_FETCH) || (state_q == ST_SEND);
    all_done  = (state_q == ST_DONE);
    lane_sel  = (state_q == ST_FETCH) ? lane_cnt : 2'd0;
    out_data  = (state_q == ST_SEND) ? mux_word : '0;
    state_dbg = state_q;
  end

  always_ff @(posedge clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      lane_cnt   <= '0;
      word_cnt   <= '0;
      digest_cnt <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lane_cnt <= '0;
          word_cnt <= '0;
        end
        ST_FETCH: begin
          lane_cnt <= (lane_cnt == LAST_LANE) ? 2'd0 : lane_cnt + 2'd1;
          word_cnt <= '0;
        end
        ST_SEND: begin
          if (handshake) begin
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
          end
          if (last_hs && (digest_cnt != N_CNT)) begin
            digest_cnt <= digest_cnt + 2'd1;
          end
        end
        default: begin
          lane_cnt <= '0;
          word_cnt <= '0;
        end
      endcase
      if (overrun_set) begin
        overrun <= 1'b1;
      end
    end
  end

  // Capture storage only; its contents are never observable outside SEND.
  always_ff @(posedge clk) begin
    if (state_q == ST_FETCH) begin
      buffer[LANE_W*lane_cnt +: LANE_W] <= lane_in;
    end
  end

  digest_word_mux u_word_mux (
    .buffer   (buffer),
    .word_idx (word_cnt),
    .word     (mux_word)
  );

endmodule

// File: doc/hash_digest_drain.md
HASH_DIGEST_DRAIN -- requirements
Module: hash_digest_drain

Interface
REQ-001 Parameter N_DIGESTS, 3, number of hash_ans results drained before completion.
REQ-002 Parameter LANES, 4, 64-bit sponge lanes per digest (256-bit digest).
REQ-003 clk  input  1  block clock, rising edge; gated hash clock domain.
REQ-004 ovr_rst1  input  1  reset, asynchronous, active-high.
REQ-005 hash_ans  input  1  single-cycle strobe; sponge state holds a valid digest.
REQ-006 hash_fin  input  1  level; producer has issued its final digest.
REQ-007 lane_in  input  64  sponge lane selected by lane_sel, valid the same cycle.
REQ-008 lane_sel  output  2  lane index being read.
REQ-009 out_data  output  32  digest word, least-significant word of lane 0 first.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-012 busy  output  1  high in FETCH or SEND.
REQ-013 digest_cnt  output  2  digests fully drained.
REQ-014 all_done  output  1  sticky; N_DIGESTS digests drained.
REQ-015 overrun  output  1  sticky; hash_ans arrived while busy.

Function
REQ-016 FSM states: IDLE, FETCH, SEND, DONE.
REQ-017 IDLE: hash_ans=1 -> FETCH with lane counter at 0, on the next edge.
REQ-018 FETCH: lane_sel = lane counter; each cycle, lane_in is written into buffer slot lane_sel and the counter increments; after slot LANES-1 -> SEND with word counter at 0.
REQ-019 FETCH takes exactly LANES cycles; lane_sel holds 0 outside FETCH.
REQ-020 SEND: out_valid=1 and out_data = buffer[32*w +: 32] for word counter w; w advances only on a handshake.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
REQ-022 On the handshake of word 2*LANES-1, digest_cnt increments by 1 on the same edge.
REQ-023 After that handshake: if the new digest_cnt equals N_DIGESTS -> DONE, otherwise -> IDLE.
REQ-024 out_valid drops in the cycle after the final-word handshake; there is no bubble-free restart.
REQ-025 DONE: all_done=1; out_valid=0; hash_ans is ignored; the state is held until reset.
REQ-026 hash_ans in FETCH or SEND: sets overrun; the strobe is dropped; the drain in progress is unaffected.
REQ-027 hash_ans in the same cycle as the final handshake (REQ-022): treated as overrun and dropped.
REQ-028 hash_fin=1 while in IDLE with digest_cnt < N_DIGESTS: sets overrun (early finish); the state stays IDLE.
REQ-029 digest_cnt saturates at N_DIGESTS and never wraps.
REQ-030 busy is high in FETCH or SEND and low otherwise.

Reset
REQ-031 ovr_rst1 high forces the following, asynchronously: state=IDLE, lane and word counters=0, digest_cnt=0, and out_valid, all_done, overrun, busy=0.
REQ-032 ovr_rst1 high forces lane_sel=0 and out_data=0.
REQ-033 The buffer is not reset.
REQ-034 Reset asserted mid-FETCH or mid-SEND aborts the drain; no partial word is issued afterwards.
REQ-035 Deassertion of ovr_rst1 is synchronous to clk; the first hash_ans is honoured one cycle after deassertion.

Structure
REQ-036 The state enum, the LANES and N_DIGESTS defaults, and the digest width constant (256) SHALL live in the shared hash package.
REQ-037 One sub-module, digest_word_mux, SHALL select a 32-bit word from the 256-bit buffer by word index; all other logic stays flat.

Verification
REQ-038 Scenario 1: reset, then hash_ans with lanes 0..3 = 64'h0..01..64'h0..04 and out_ready=1 -> after 4 FETCH cycles, 8 words 1,0,2,0,3,0,4,0 on consecutive cycles; digest_cnt=1.
REQ-039 Scenario 2: out_ready toggling 1,0,0,1 during SEND -> out_data holds stable while stalled; word order unchanged; 8 handshakes total.
REQ-040 Scenario 3: three digests drained back to back -> digest_cnt=3; all_done=1; a fourth hash_ans produces no out_valid.
REQ-041 Scenario 4: hash_ans pulsed in FETCH cycle 2 -> overrun=1; the current digest completes; no extra digest is issued.
REQ-042 Scenario 5: ovr_rst1 pulsed at SEND word 3 -> out_valid=0 immediately; a new hash_ans drains a full 8 words starting from word 0.
REQ-043 Scenario 6: hash_fin=1 in IDLE with digest_cnt=1 -> overrun=1; state remains IDLE; all_done=0.
